input_spi: RTL and testbench

SPI byte receiver: the receiving end of the team's serial byte link, deserialising what `outputSPI` drives on its `out` / `clk_out` / `en_out` pins. It oversamples the incoming serial clock, frame enable and data on the system clock. It shifts in 8-bit words and presents each completed byte through a valid/ready holding register, flagging overruns and truncated frames. It sits at the front of the decrypt datapath, feeding bytes to the cipher core.

---
 rtl/input_spi.sv | 131 +++++++++++++
 tb/tb_input_spi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_spi.sv
// SPI byte receiver: oversamples sclk/cs/sdi on clk, shifts in DATA_W-bit words
// and presents each one through a single-entry valid/ready holding register.
module input_spi #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sclk_in,
    input  logic              cs_in,
    input  logic              sdi,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sdi_s;
    logic                   sclk_d;
    logic                   rise;

    logic [0:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-1:0]      sr;
    logic [DATA_W-1:0]      sr_next;
    logic [DATA_W-1:0]      word;
    logic                   done;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign busy   = en & cs_s;

    assign sr_next = (MSB_FIRST != 0) ? {sr[DATA_W-2:0], sdi_s}
                                      : {sdi_s, sr[DATA_W-1:1]};

    // All three inputs share one synchroniser depth so sdi_s stays aligned to rise.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            word      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_d    <= sclk_s;
            frame_err <= 1'b0;
            done      <= 1'b0;

            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_s) begin
                            state <= SHIFT;
                            cnt   <= '0;
                            sr    <= '0;
                        end
                    end
                    default: begin
                        // Abort takes priority over a coincident sclk rise.
                        if (!cs_s) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            frame_err <= (cnt != '0);
                        end else if (rise) begin
                            sr <= sr_next;
                            if (cnt == LAST_BIT) begin
                                cnt  <= '0;
                                word <= sr_next;
                                done <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Holding register: a completed word loads only if the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    out   <= word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_spi.sv
// Directed bench for input_spi: drives SPI frames at sclk = clk/4 and checks
// received bytes, flags, busy and valid latency against hand-computed values.
module tb_input_spi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sclk_in = 1'b0;
    logic       cs_in = 1'b0;
    logic       sdi = 1'b0;
    logic [7:0] out;
    logic       valid;
    logic       ready = 1'b1;
    logic       busy;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int first_valid_cyc = -1;
    int valid_cycles = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] rx_q[$];

    input_spi #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .en(en), .sclk_in(sclk_in), .cs_in(cs_in), .sdi(sdi),
        .out(out), .valid(valid), .ready(ready), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (ready) rx_q.push_back(out);
            end
            if (overrun) ov_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_stats();
        rx_q.delete();
        valid_cycles = 0;
        first_valid_cyc = -1;
        ov_cnt = 0;
        fe_cnt = 0;
    endtask

    // Send the top nbits of b, MSB first: sdi set at start of low phase, 2 clk low, 2 clk high.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = b[i];
            sclk_in = 1'b0;
            clks(2);
            sclk_in = 1'b1;
            last_rise_cyc = cyc;
            clks(2);
        end
        sclk_in = 1'b0;
    endtask

    task automatic frame_start();
        cs_in = 1'b1;
        clks(3);
    endtask

    task automatic frame_end();
        clks(2);
        cs_in = 1'b0;
        clks(8);
    endtask

    initial begin
        clks(3);
        check("reset_out", {24'h0, out}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        clks(2);

        // Single byte: valid must rise 3 edges after the edge sampling the last rise.
        clear_stats();
        frame_start();
        send_bits(8'hA5, 8);
        frame_end();
        check("single_count", rx_q.size(), 1);
        check("single_data", rx_at(0), 32'hA5);
        check("single_valid_len", valid_cycles, 1);
        check("single_latency", first_valid_cyc - last_rise_cyc, 4);
        check("single_flags", ov_cnt + fe_cnt, 0);

        // Multi-byte frame.
        clear_stats();
        frame_start();
        check("multi_busy_start", {31'h0, busy}, 32'h1);
        send_bits(8'h00, 8);
        send_bits(8'hFF, 8);
        check("multi_busy_mid", {31'h0, busy}, 32'h1);
        send_bits(8'h01, 8);
        frame_end();
        check("multi_busy_end", {31'h0, busy}, 32'h0);
        check("multi_count", rx_q.size(), 3);
        check("multi_b0", rx_at(0), 32'h00);
        check("multi_b1", rx_at(1), 32'hFF);
        check("multi_b2", rx_at(2), 32'h01);
        check("multi_frame_err", fe_cnt, 0);

        // Overrun: second byte dropped while the first is unread.
        clear_stats();
        ready = 1'b0;
        frame_start();
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        frame_end();
        check("ovr_out", {24'h0, out}, 32'h11);
        check("ovr_valid", {31'h0, valid}, 32'h1);
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_no_drain", rx_q.size(), 0);
        ready = 1'b1;
        clks(4);
        check("ovr_drain_count", rx_q.size(), 1);
        check("ovr_drain_data", rx_at(0), 32'h11);
        check("ovr_valid_clear", {31'h0, valid}, 32'h0);

        // Truncated frame after 5 bits, then a clean frame.
        clear_stats();
        frame_start();
        send_bits(8'hF0, 5);
        frame_end();
        check("trunc_frame_err", fe_cnt, 1);
        check("trunc_no_valid", valid_cycles, 0);
        frame_start();
        send_bits(8'h3C, 8);
        frame_end();
        check("trunc_next_data", rx_at(0), 32'h3C);
        check("trunc_next_count", rx_q.size(), 1);
        check("trunc_no_new_err", fe_cnt, 1);

        // Reset for one edge after 4 bits; out holds 0x3C beforehand.
        clear_stats();
        frame_start();
        send_bits(8'hC3, 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_out", {24'h0, out}, 32'h0);
        check("rst_mid_valid", {31'h0, valid}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        cs_in = 1'b0;
        clks(6);
        frame_start();
        send_bits(8'h5A, 8);
        frame_end();
        check("rst_mid_next_data", rx_at(0), 32'h5A);
        check("rst_mid_count", rx_q.size(), 1);
        check("rst_mid_no_err", fe_cnt, 0);

        // Loopback-style back-to-back stream.
        clear_stats();
        frame_start();
        send_bits(8'hFF, 8);
        send_bits(8'h00, 8);
        send_bits(8'h01, 8);
        send_bits(8'h02, 8);
        send_bits(8'h03, 8);
        frame_end();
        check("loop_count", rx_q.size(), 5);
        check("loop_b0", rx_at(0), 32'hFF);
        check("loop_b1", rx_at(1), 32'h00);
        check("loop_b2", rx_at(2), 32'h01);
        check("loop_b3", rx_at(3), 32'h02);
        check("loop_b4", rx_at(4), 32'h03);
        check("loop_flags", ov_cnt + fe_cnt, 0);

        // Enable low mid-byte: no frame_err, receiver idle.
        clear_stats();
        frame_start();
        send_bits(8'hAA, 3);
        en = 1'b0;
        clks(2);
        check("en_low_busy", {31'h0, busy}, 32'h0);
        cs_in = 1'b0;
        clks(4);
        en = 1'b1;
        clks(4);
        check("en_low_no_err", fe_cnt, 0);
        check("en_low_no_valid", valid_cycles, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
